// File: rtl/qf_sff_wr_arb_if.sv
// Write-side bundle between packet requesters, the round-robin arbiter and the qf_sff FIFO write port.
// The arbiter connects as slave; requesters and the FIFO flag source connect as master.
interface qf_sff_wr_arb_if #(
  parameter int PAR_NUM_REQ         = 4,
  parameter int PAR_FIFO_DATA_WIDTH = 32
);
  logic [PAR_NUM_REQ-1:0]                     req_valid;
  logic [PAR_NUM_REQ-1:0]                     req_last;
  logic [PAR_NUM_REQ*PAR_FIFO_DATA_WIDTH-1:0] req_data;
  logic [PAR_NUM_REQ-1:0]                     req_ready;
  logic                                       fifo_full_flag;
  logic                                       fifo_wr_en;
  logic [PAR_FIFO_DATA_WIDTH-1:0]             fifo_wr_data;

  modport master (
    output req_valid, req_last, req_data, fifo_full_flag,
    input  req_ready, fifo_wr_en, fifo_wr_data
  );

  modport slave (
    input  req_valid, req_last, req_data, fifo_full_flag,
    output req_ready, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/qf_sff_wr_arb.sv
// Round-robin packet arbiter in front of a qf_sff write port: 1-cycle grant latency, one idle bubble per grant,
// FIFO full stalls the grant in place. Define QF_SFF_WR_ARB_BURST_LIMIT_EN to also cut grants at PAR_MAX_BURST beats.
module qf_sff_wr_arb #(
  parameter int PAR_NUM_REQ         = 4,
  parameter int PAR_REQ_IDX_BITS    = 2,
  parameter int PAR_FIFO_DATA_WIDTH = 32,
  parameter int PAR_MAX_BURST       = 8,
  parameter int PAR_BURST_CNT_BITS  = 4
) (
  input  logic                        fifo_clk,
  input  logic                        fifo_rst_n,
  qf_sff_wr_arb_if.slave              bus,
  output logic                        arb_busy,
  output logic [PAR_REQ_IDX_BITS-1:0] arb_gnt_idx,
  output logic [PAR_NUM_REQ-1:0]      arb_gnt_vec
);

`ifdef QF_SFF_WR_ARB_BURST_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam logic [PAR_BURST_CNT_BITS-1:0] CNT_MAX  = {PAR_BURST_CNT_BITS{1'b1}};
  localparam logic [PAR_BURST_CNT_BITS-1:0] CNT_LAST = PAR_BURST_CNT_BITS'(PAR_MAX_BURST - 1);
  localparam logic [PAR_NUM_REQ-1:0]        ONE_VEC  = PAR_NUM_REQ'(1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                          state;
  logic [PAR_REQ_IDX_BITS-1:0]     gnt_idx;
  logic [PAR_BURST_CNT_BITS-1:0]   burst_cnt;
  logic                            busy;
  logic [PAR_NUM_REQ-1:0]          gnt_vec;

  logic [PAR_FIFO_DATA_WIDTH-1:0]  lane_data [PAR_NUM_REQ];
  logic [PAR_REQ_IDX_BITS-1:0]     next_idx;
  logic [PAR_REQ_IDX_BITS-1:0]     cand;
  logic                            found;
  logic                            any_valid;
  logic                            accept;
  logic                            burst_hit;
  logic                            burst_end;

  for (genvar i = 0; i < PAR_NUM_REQ; i++) begin : g_lane
    assign lane_data[i] = bus.req_data[i*PAR_FIFO_DATA_WIDTH +: PAR_FIFO_DATA_WIDTH];
  end

  // gnt_idx doubles as last_gnt: scan starts one past it and wraps
  always_comb begin
    next_idx = gnt_idx;
    cand     = gnt_idx;
    found    = 1'b0;
    for (int k = 1; k <= PAR_NUM_REQ; k++) begin
      cand = PAR_REQ_IDX_BITS'((int'(gnt_idx) + k) % PAR_NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found    = 1'b1;
        next_idx = cand;
      end
    end
  end

  assign any_valid = |bus.req_valid;

  // gnt_vec is zero outside BURST, so ready needs no separate state term
  assign bus.req_ready    = gnt_vec & {PAR_NUM_REQ{~bus.fifo_full_flag}};
  assign accept           = |(bus.req_valid & bus.req_ready);
  assign bus.fifo_wr_en   = accept;
  assign bus.fifo_wr_data = lane_data[gnt_idx];

  assign burst_hit = (burst_cnt == CNT_LAST);
  assign burst_end = accept & (bus.req_last[gnt_idx] | (LIMIT_EN & burst_hit));

  always_ff @(posedge fifo_clk or negedge fifo_rst_n) begin
    if (!fifo_rst_n) begin
      state     <= IDLE;
      gnt_idx   <= PAR_REQ_IDX_BITS'(PAR_NUM_REQ - 1);
      burst_cnt <= '0;
      busy      <= 1'b0;
      gnt_vec   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            state     <= BURST;
            gnt_idx   <= next_idx;
            burst_cnt <= '0;
            busy      <= 1'b1;
            gnt_vec   <= ONE_VEC << next_idx;
          end
        end
        BURST: begin
          if (accept) begin
            if (burst_cnt != CNT_MAX) begin
              burst_cnt <= burst_cnt + 1'b1;
            end
            if (burst_end) begin
              state   <= IDLE;
              busy    <= 1'b0;
              gnt_vec <= '0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          gnt_vec <= '0;
        end
      endcase
    end
  end

  assign arb_busy    = busy;
  assign arb_gnt_idx = gnt_idx;
  assign arb_gnt_vec = gnt_vec;

endmodule
